// File: rtl/keccak_pi_inv_stream_pkg.sv
// ============================================================================
// Module   : keccak_pi_inv_stream_pkg
// Brief    : Shared constants for the lane-serial inverse-pi reorder block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package keccak_pi_inv_stream_pkg;

  localparam int NLANES  = 25;
  localparam int CNT_W   = 5;
  localparam int STATE_W = 1;

  localparam logic [STATE_W-1:0] ST_FILL = 1'b0;
  localparam logic [STATE_W-1:0] ST_FULL = 1'b1;

  localparam logic [CNT_W-1:0] LAST_CNT = 5'(NLANES - 1);

  // Destination lane for the n-th arriving lane; shared with the forward-pi check model.
  localparam logic [CNT_W-1:0] PI_INV_DST [NLANES] = '{
    5'd0,  5'd10, 5'd20, 5'd5,  5'd15,
    5'd16, 5'd1,  5'd11, 5'd21, 5'd6,
    5'd7,  5'd17, 5'd2,  5'd12, 5'd22,
    5'd23, 5'd8,  5'd18, 5'd3,  5'd13,
    5'd14, 5'd24, 5'd9,  5'd19, 5'd4
  };

endpackage

`default_nettype wire

// File: rtl/keccak_pi_inv_stream.sv
// ============================================================================
// Module   : keccak_pi_inv_stream
// Brief    : Scatters 25 serial lanes into a parallel state at inverse-pi slots.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module keccak_pi_inv_stream #(
  parameter int LANE_W = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANE_W-1:0]     in_lane,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [25*LANE_W-1:0]  state_out,
  output logic                  len_err
);

  import keccak_pi_inv_stream_pkg::*;

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_next_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [LANE_W-1:0]  r_buf [NLANES];
  logic               r_len_err;
  logic               w_accept;
  logic               w_cnt_last;
  logic [CNT_W-1:0]   w_dst;

  assign w_accept   = in_valid & in_ready;
  assign w_cnt_last = (r_cnt == LAST_CNT);
  assign w_dst      = PI_INV_DST[r_cnt];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_FILL: if (w_accept && w_cnt_last) w_next_state = ST_FULL;
      ST_FULL: if (out_ready)              w_next_state = ST_FILL;
      default:                             w_next_state = ST_FILL;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      ST_FILL: in_ready  = 1'b1;
      ST_FULL: out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // The lane count alone defines the frame; in_last only feeds the sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_len_err <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= w_cnt_last ? '0 : r_cnt + 5'd1;
      if (in_last != w_cnt_last) r_len_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NLANES; i++) r_buf[i] <= '0;
    end else if (w_accept) begin
      r_buf[w_dst] <= in_lane;
    end
  end

  generate
    for (genvar l = 0; l < NLANES; l++) begin : g_pack
      assign state_out[l*LANE_W +: LANE_W] = r_buf[l];
    end
  endgenerate

  assign len_err = r_len_err;

endmodule

`default_nettype wire

// File: tb/tb_keccak_pi_inv_stream.sv
// ============================================================================
// Module   : tb_keccak_pi_inv_stream
// Brief    : Random-stimulus scoreboard bench for the inverse-pi lane reorder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keccak_pi_inv_stream;

  localparam int LANE_W = 64;
  typedef logic [LANE_W-1:0]    lane_t;
  typedef logic [25*LANE_W-1:0] state_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   in_valid = 1'b0;
  logic   in_ready;
  lane_t  in_lane = '0;
  logic   in_last = 1'b0;
  logic   out_valid;
  logic   out_ready = 1'b0;
  state_t state_out;
  logic   len_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  state_t sb[$];

  keccak_pi_inv_stream #(.LANE_W(LANE_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_lane   (in_lane),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_out (state_out),
    .len_err   (len_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Source lane n = 5*y'+x' lands at L = 5*((2x'+3y') mod 5) + y'.
  function automatic int dst_of(input int n);
    int xp, yp;
    xp = n % 5;
    yp = n / 5;
    return 5 * ((2 * xp + 3 * yp) % 5) + yp;
  endfunction

  function automatic lane_t lane_of(input state_t s, input int l);
    return s[l*LANE_W +: LANE_W];
  endfunction

  function automatic state_t rand_state();
    state_t s;
    for (int l = 0; l < 25; l++) s[l*LANE_W +: LANE_W] = {$urandom, $urandom};
    return s;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string name, input state_t act, input state_t exp);
    int d;
    d = -1;
    for (int l = 24; l >= 0; l--) if (lane_of(act, l) !== lane_of(exp, l)) d = l;
    checks++;
    if (d >= 0) begin
      errors++;
      $display("FAIL %s: lane %0d got %0h expected %0h", name, d, lane_of(act, d), lane_of(exp, d));
    end
  endtask

  // Scoreboard monitor: every output handshake pops one expected state.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got a state with empty scoreboard");
      end else begin
        chk_state("state_out", state_out, sb.pop_front());
      end
    end
  end

  task automatic send_lane(input lane_t d, input logic last, input int max_gap, output int acc_cyc);
    int gap, waited;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (gap) begin
      in_valid = 1'b0;
      in_lane  = {$urandom, $urandom};
      in_last  = 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_lane  = d;
    in_last  = last;
    waited   = 0;
    acc_cyc  = -1;
    while (acc_cyc < 0) begin
      @(negedge clk);
      if (in_ready) acc_cyc = cyc;
      else if (++waited > 100) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: in_ready 0 expected 1");
        acc_cyc = cyc;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_state(input state_t s, input int bad_last, input int max_gap,
                            output int first_acc, output int last_acc);
    int a;
    sb.push_back(s);
    first_acc = 0;
    last_acc  = 0;
    for (int n = 0; n < 25; n++) begin
      send_lane(lane_of(s, dst_of(n)), (n == 24) || (n == bad_last), max_gap, a);
      if (n == 0) first_acc = a;
      last_acc = a;
    end
  endtask

  initial begin
    state_t s, snap;
    int f, l, prev_l, a, waited;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_len_err",   64'(len_err),   64'd0);
    chk("reset_in_ready",  64'(in_ready),  64'd1);
    chk_state("reset_state", state_out, '0);

    // Identity pattern with the consumer stalled so the result can be inspected.
    for (int n = 0; n < 25; n++) s[dst_of(n)*LANE_W +: LANE_W] = lane_t'(n);
    send_state(s, -1, 0, f, l);
    chk("ident_out_valid", 64'(out_valid), 64'd1);
    chk("ident_in_ready",  64'(in_ready),  64'd0);
    chk("ident_lane10", lane_of(state_out, 10), 64'd1);
    chk("ident_lane1",  lane_of(state_out, 1),  64'd6);
    chk("ident_lane24", lane_of(state_out, 24), 64'd21);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("ident_in_ready_after", 64'(in_ready),  64'd1);
    chk("ident_out_valid_after", 64'(out_valid), 64'd0);

    // Back-to-back round trips: one idle cycle between the last and next first accept.
    out_ready = 1'b1;
    prev_l = 0;
    for (int k = 0; k < 3; k++) begin
      send_state(rand_state(), -1, 0, f, l);
      if (k > 0) chk("rt_gap", 64'(f - prev_l), 64'd2);
      prev_l = l;
    end
    @(posedge clk); #1;

    // Backpressure in FULL with in_valid held high.
    out_ready = 1'b0;
    send_state(rand_state(), -1, 0, f, l);
    snap     = state_out;
    in_valid = 1'b1;
    in_lane  = {$urandom, $urandom};
    repeat (10) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk_state("bp_stable", state_out, snap);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);

    // Random bubbles, then a misplaced in_last.
    out_ready = 1'b1;
    send_state(rand_state(), -1, 3, f, l);
    chk("bubble_len_err", 64'(len_err), 64'd0);
    send_state(rand_state(), 7, 1, f, l);
    chk("lenerr_set", 64'(len_err), 64'd1);
    send_state(rand_state(), -1, 0, f, l);
    @(posedge clk); #1;
    chk("lenerr_sticky", 64'(len_err), 64'd1);
    repeat (2) @(posedge clk);
    #1;

    // Mid-fill reset discards the partial state.
    s = rand_state();
    for (int n = 0; n < 12; n++) send_lane(lane_of(s, dst_of(n)), 1'b0, 0, a);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("mid_len_err",   64'(len_err),   64'd0);
    chk("mid_out_valid", 64'(out_valid), 64'd0);
    chk("mid_in_ready",  64'(in_ready),  64'd1);
    chk_state("mid_state_cleared", state_out, '0);
    send_state(rand_state(), -1, 2, f, l);
    chk("mid_len_err_after", 64'(len_err), 64'd0);

    waited = 0;
    while (sb.size() != 0 && waited < 100) begin
      @(posedge clk);
      waited++;
    end
    #1;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
